// File: rtl/udp_tx_pkt_buffer.sv
// udp_tx_pkt_buffer: store-and-forward packet buffer in front of the UDP/IP user transmit port.
// Whole packets are buffered and sized, then replayed with a {dst_ip, dst_port, byte_len} descriptor.
module udp_tx_pkt_buffer #(
   parameter int ADDR_W     = 9,
   parameter int MAX_WORDS  = 368,
   parameter int DESC_DEPTH = 4
) (
   input  logic        sclk,
   input  logic        reset_n,
   input  logic [31:0] dst_ip_i,
   input  logic [15:0] dst_port_i,
   input  logic        in_vld_i,
   input  logic [31:0] in_data_i,
   input  logic [3:0]  in_be_i,
   input  logic        in_last_i,
   output logic        in_rdy_o,
   output logic        tx_usr_data_vld_o,
   output logic [31:0] tx_usr_data_o,
   output logic [63:0] tx_user_o,
   output logic [3:0]  tx_usr_be_o,
   output logic        tx_usr_tlast_o,
   input  logic        tx_usr_ready_i,
   output logic        drop_o,
   output logic [15:0] pkt_cnt_o
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int WC_W  = $clog2(MAX_WORDS + 1);
   localparam int DP_W  = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;

   typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_SEND} rd_state_e;

   logic [36:0]     word_mem [DEPTH];
   logic [36:0]     mem_q;
   logic [ADDR_W:0] wr_ptr, wr_inc, start_ptr, rd_ptr, rd_inc, used_words;
   logic [ADDR_W-1:0] rd_addr;
   logic [WC_W-1:0] wcnt, wcnt_inc;
   logic [15:0]     byte_cnt, pkt_len;
   logic [31:0]     cur_ip, pkt_ip;
   logic [15:0]     cur_port, pkt_port;
   logic            discard, alive, first_word;
   logic            buf_full, desc_full, desc_empty;
   logic            accept, drop_now, commit, wr_en;
   logic [3:0]      be_fix;
   logic [2:0]      last_bytes;

   logic [31:0]     desc_ip    [DESC_DEPTH];
   logic [15:0]     desc_port  [DESC_DEPTH];
   logic [15:0]     desc_len   [DESC_DEPTH];
   logic [ADDR_W:0] desc_start [DESC_DEPTH];
   logic [DP_W-1:0] dwp, drp;
   logic [DP_W:0]   dcnt;

   rd_state_e       state, state_nxt;
   logic            load_desc, advance, desc_pop;

   assign used_words = wr_ptr - rd_ptr;
   assign buf_full   = (used_words == {1'b1, {ADDR_W{1'b0}}});
   assign desc_full  = (dcnt == (DP_W+1)'(DESC_DEPTH));
   assign desc_empty = (dcnt == '0);
   assign first_word = (wcnt == '0);
   assign wr_inc     = wr_ptr + 1'b1;
   assign rd_inc     = rd_ptr + 1'b1;
   assign wcnt_inc   = wcnt + 1'b1;

   // A full buffer stalls only at a packet boundary; mid-packet it forces a drop instead.
   assign in_rdy_o = alive && (discard || (!desc_full && !(buf_full && first_word)));
   assign accept   = in_vld_i && in_rdy_o;
   assign drop_now = accept && !discard &&
                     ((!first_word && buf_full) || (!in_last_i && wcnt_inc == WC_W'(MAX_WORDS)));
   assign commit   = accept && !discard && !drop_now && in_last_i;
   assign wr_en    = accept && !discard && !drop_now;

   always_comb begin
      be_fix = 4'hF;
      if (in_last_i && (in_be_i == 4'hE || in_be_i == 4'hC || in_be_i == 4'h8))
         be_fix = in_be_i;
      case (be_fix)
         4'hE:    last_bytes = 3'd3;
         4'hC:    last_bytes = 3'd2;
         4'h8:    last_bytes = 3'd1;
         default: last_bytes = 3'd4;
      endcase
   end

   assign pkt_len  = byte_cnt + 16'(last_bytes);
   assign pkt_ip   = first_word ? dst_ip_i : cur_ip;
   assign pkt_port = first_word ? dst_port_i : cur_port;

   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         start_ptr <= '0;
         wcnt      <= '0;
         byte_cnt  <= '0;
         cur_ip    <= '0;
         cur_port  <= '0;
         discard   <= 1'b0;
         alive     <= 1'b0;
         drop_o    <= 1'b0;
      end else begin
         alive  <= 1'b1;
         drop_o <= drop_now;
         if (drop_now) begin
            wr_ptr   <= start_ptr;
            wcnt     <= '0;
            byte_cnt <= '0;
            discard  <= !in_last_i;
         end else if (accept && discard) begin
            if (in_last_i) discard <= 1'b0;
         end else if (commit) begin
            wr_ptr    <= wr_inc;
            start_ptr <= wr_inc;
            wcnt      <= '0;
            byte_cnt  <= '0;
         end else if (wr_en) begin
            wr_ptr   <= wr_inc;
            wcnt     <= wcnt_inc;
            byte_cnt <= byte_cnt + 16'd4;
            if (first_word) begin
               cur_ip   <= dst_ip_i;
               cur_port <= dst_port_i;
            end
         end
      end
   end

   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         dwp  <= '0;
         drp  <= '0;
         dcnt <= '0;
      end else begin
         if (commit)   dwp <= dwp + 1'b1;
         if (desc_pop) drp <= drp + 1'b1;
         case ({commit, desc_pop})
            2'b10:   dcnt <= dcnt + 1'b1;
            2'b01:   dcnt <= dcnt - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge sclk) begin
      if (commit) begin
         desc_ip[dwp]    <= pkt_ip;
         desc_port[dwp]  <= pkt_port;
         desc_len[dwp]   <= pkt_len;
         desc_start[dwp] <= start_ptr;
      end
   end

   // mem_q always holds the word at rd_ptr, acting as the prefetch stage behind the output register.
   always_ff @(posedge sclk) begin
      if (wr_en) word_mem[wr_ptr[ADDR_W-1:0]] <= {in_data_i, be_fix, in_last_i};
      mem_q <= word_mem[rd_addr];
   end

   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) state <= RD_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RD_IDLE: if (!desc_empty) state_nxt = RD_LOAD;
         RD_LOAD: state_nxt = RD_SEND;
         RD_SEND: if (tx_usr_ready_i && tx_usr_tlast_o) state_nxt = RD_IDLE;
         default: state_nxt = RD_IDLE;
      endcase
   end

   always_comb begin
      load_desc = (state == RD_IDLE) && !desc_empty;
      advance   = (state == RD_LOAD) || ((state == RD_SEND) && tx_usr_ready_i && !tx_usr_tlast_o);
      desc_pop  = (state == RD_SEND) && tx_usr_ready_i && tx_usr_tlast_o;
      rd_addr   = rd_ptr[ADDR_W-1:0];
      if (load_desc)    rd_addr = desc_start[drp][ADDR_W-1:0];
      else if (advance) rd_addr = rd_inc[ADDR_W-1:0];
   end

   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr            <= '0;
         tx_user_o         <= '0;
         tx_usr_data_o     <= '0;
         tx_usr_be_o       <= '0;
         tx_usr_tlast_o    <= 1'b0;
         tx_usr_data_vld_o <= 1'b0;
         pkt_cnt_o         <= '0;
      end else begin
         if (load_desc) begin
            tx_user_o <= {desc_ip[drp], desc_port[drp], desc_len[drp]};
            rd_ptr    <= desc_start[drp];
         end
         if (advance) begin
            {tx_usr_data_o, tx_usr_be_o, tx_usr_tlast_o} <= mem_q;
            tx_usr_data_vld_o <= 1'b1;
            rd_ptr            <= rd_inc;
         end
         if (desc_pop) begin
            tx_usr_data_vld_o <= 1'b0;
            tx_usr_tlast_o    <= 1'b0;
            pkt_cnt_o         <= pkt_cnt_o + 1'b1;
         end
      end
   end

endmodule

// File: doc/udp_tx_pkt_buffer.md
# udp_tx_pkt_buffer

Store-and-forward packet buffer directly upstream of the UDP/IP stack's user transmit port. It accepts a 32-bit user word stream with byte enables and tlast, and holds each packet until it is complete. It then computes the payload byte length and replays the packet with a 64-bit sideband descriptor on the `tx_usr_*` interface. Packets that overflow the buffer or exceed the size limit are discarded whole, so the stack never sees a truncated frame.

## Interface
- `ADDR_W`, 9: word-buffer address width; capacity is 2^ADDR_W words.
- `MAX_WORDS`, 368: maximum payload words per packet (1472 bytes).
- `DESC_DEPTH`, 4: number of committed packets that can be held (power of 2).

Ports:
- `sclk` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous assert, active-low reset.
- `dst_ip_i` in 32: destination IP, sampled with the first word of each packet.
- `dst_port_i` in 16: destination UDP port, sampled with the first word.
- `in_vld_i` in 1: input word valid.
- `in_data_i` in 32: input word, byte 0 in bits [31:24].
- `in_be_i` in 4: byte enables; 4'hF on all non-last words.
- `in_last_i` in 1: last word of the packet.
- `in_rdy_o` out 1: input ready.
- `tx_usr_data_vld_o` out 1: output valid, to the stack's `tx_usr_data_vld_i`.
- `tx_usr_data_o` out 32: output word.
- `tx_user_o` out 64: descriptor {dst_ip[63:32], dst_port[31:16], byte_len[15:0]}, held for the whole packet.
- `tx_usr_be_o` out 4: output byte enables.
- `tx_usr_tlast_o` out 1: last word of the packet.
- `tx_usr_ready_i` in 1: ready from the stack.
- `drop_o` out 1: one-cycle pulse when an input packet is discarded.
- `pkt_cnt_o` out 16: count of packets sent; wraps at 16'hFFFF to 0.

## Operation
Write side:
- Word transfer occurs when `in_vld_i && in_rdy_o`.
- The word, be and last are written at `wr_ptr`.
- `wr_ptr` advances and `wcnt` (words in the current packet) increments.
- The byte count accumulates 4 per non-last word. On the last word it adds the popcount of `in_be_i`.
- Legal last-word be values are F, E, C and 8. Any other last-word be is treated as F.
- On the first word, capture `dst_ip_i` and `dst_port_i`.

Commit:
- On the last word, push {ip, port, byte_len, start_ptr} into the descriptor FIFO.
- `start_ptr` then becomes `wr_ptr + 1`.

Drop:
- A drop is triggered when `wcnt` reaches `MAX_WORDS` without last, or when the word buffer is full mid-packet.
- On drop, `wr_ptr` rewinds to `start_ptr` and `drop_o` pulses.
- The block then enters DISCARD. In DISCARD, `in_rdy_o` = 1 and words are swallowed through and including the last word.

`in_rdy_o` = 0 when either:
- the descriptor FIFO is full and not in DISCARD, or
- the buffer is full and not in DISCARD. This case only applies at the first word of a packet, where the block stalls rather than dropping.

Read FSM states:
- IDLE: when the descriptor FIFO is non-empty, load the descriptor into `tx_user_o`, issue a buffer read at `rd_ptr`, and go to LOAD.
- LOAD: read data lands in the output register; assert valid; go to SEND.
- SEND: on `tx_usr_ready_i`, pop the next word. Use a skid/prefetch register so transfers are back-to-back. On the handshake of the last word, pop the descriptor, increment `pkt_cnt_o`, and go to IDLE.

Buffer occupancy:
- Full = `wr_ptr - rd_ptr` equals 2^ADDR_W, using ADDR_W+1-bit pointers.
- Pointers wrap naturally.
- Read space freed by SEND becomes visible to the write side on the next cycle.

Simultaneous events:
- A descriptor push and pop in the same cycle are both honoured, and the count is unchanged.
- A commit and an IDLE check in the same cycle: the new packet is seen next cycle.

Reset:
- All pointers, counters and the FSM return to IDLE; the buffer contents are don't-care.
- A packet partly written or partly sent is lost. There is no partial output after reset.

## Timing
Reset values:
- `in_rdy_o` = 0 during reset and becomes 1 on the first cycle after deassertion.
- `tx_usr_data_vld_o`, `tx_usr_tlast_o`, `drop_o` = 0.
- `tx_user_o`, `tx_usr_data_o`, `tx_usr_be_o`, `pkt_cnt_o` = 0.

Latency and throughput:
- From the input last-word handshake to `tx_usr_data_vld_o` = 1 is 3 cycles (commit, IDLE, LOAD).
- Output sustains 1 word/cycle while `tx_usr_ready_i` = 1.
- Input sustains 1 word/cycle when space is available.

Output handshake:
- While valid and not ready, data, be, last and user hold stable.
- Valid never deasserts mid-packet without a handshake.
- `tx_user_o` is stable from the first word to the last word.

`drop_o` timing: asserted in the cycle after the offending word.

## Test plan
- Single packet: 3 words, last be = C, dst 0xC0A8_0001:0x1F90. Expect 3 output words identical to the input, and `tx_user_o` = 0xC0A80001_1F90_000A. First valid arrives 3 cycles after the last input.
- Back-to-back packets with `tx_usr_ready_i` = 1: 4 packets of 1, 2, 368 and 5 words. Expect the output order preserved, no gap within a packet, and `pkt_cnt_o` = 4.
- Backpressure: `tx_usr_ready_i` toggles randomly at 50%. Expect data and user to hold while stalled and no word lost or duplicated, checked by scoreboard.
- Oversize packet: 369 words without last, then a valid 2-word packet. Expect one `drop_o` pulse, the oversize packet absent from the output, and the 2-word packet emitted with length 8.
- Buffer and descriptor full: with ready = 0, write 5 one-word packets. Expect `in_rdy_o` = 0 after the 4th packet commits. Raise ready and expect all 5 packets to emerge.
- Reset mid-SEND: assert `reset_n` = 0 during word 2 of 4. Expect all outputs at reset values, with valid = 0 and `pkt_cnt_o` = 0. A fresh packet afterwards is sent correctly.
